// File: rtl/openeye_acc_pkg.sv
// Shared definitions for the accumulator/requantizer slice:
// FSM state encodings, default datapath widths and the saturation-limit helpers.
package openeye_acc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        OUTPUT = 2'd2
    } acc_state_t;

    localparam int unsigned PROD_WIDTH_DEF = 20;
    localparam int unsigned ACC_WIDTH_DEF  = 24;
    localparam int unsigned OUT_WIDTH_DEF  = 8;

    // Largest value representable in a signed field of the given width (width <= 31).
    function automatic int signed sat_max(input int unsigned width);
        return (32'sd1 <<< (width - 1)) - 32'sd1;
    endfunction

    // Smallest value representable in a signed field of the given width (width <= 31).
    function automatic int signed sat_min(input int unsigned width);
        return -(32'sd1 <<< (width - 1));
    endfunction

endpackage

// File: rtl/requant_sat.sv
// Combinational requantizer: round-half-up, arithmetic shift by the fraction,
// optional ReLU, then saturation to the output width.
// Optional ReLU is enabled by defining ACCUMULATOR_REQUANT_RELU_EN.
module requant_sat
    import openeye_acc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH_ACC = ACC_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH_OUT = OUT_WIDTH_DEF,
    parameter int unsigned Q_BITWIDTH     = $clog2(DATA_WIDTH_ACC)
) (
    input  logic signed [DATA_WIDTH_ACC-1:0] acc_next,
    input  logic        [Q_BITWIDTH-1:0]     frac,
    output logic signed [DATA_WIDTH_OUT-1:0] result,
    output logic                             sat
);

    localparam logic signed [DATA_WIDTH_ACC:0] OUT_MAX =
        (DATA_WIDTH_ACC+1)'(sat_max(DATA_WIDTH_OUT));
    localparam logic signed [DATA_WIDTH_ACC:0] OUT_MIN =
        (DATA_WIDTH_ACC+1)'(sat_min(DATA_WIDTH_OUT));
    localparam logic signed [DATA_WIDTH_OUT-1:0] RES_MAX =
        DATA_WIDTH_OUT'(sat_max(DATA_WIDTH_OUT));
    localparam logic signed [DATA_WIDTH_OUT-1:0] RES_MIN =
        DATA_WIDTH_OUT'(sat_min(DATA_WIDTH_OUT));

    logic signed [DATA_WIDTH_ACC:0] widened;
    logic signed [DATA_WIDTH_ACC:0] rounding;
    logic signed [DATA_WIDTH_ACC:0] shifted;

    // Round, shift, optionally rectify, then clamp into the output range.
    always_comb begin
        widened  = (DATA_WIDTH_ACC+1)'(acc_next);
        rounding = '0;
        if (frac != '0) begin
            rounding = {{DATA_WIDTH_ACC{1'b0}}, 1'b1} << (frac - 1'b1);
        end
        shifted = (widened + rounding) >>> frac;
`ifdef ACCUMULATOR_REQUANT_RELU_EN
        if (shifted[DATA_WIDTH_ACC]) begin
            shifted = '0;
        end
`endif
        sat    = 1'b0;
        result = shifted[DATA_WIDTH_OUT-1:0];
        if (shifted > OUT_MAX) begin
            result = RES_MAX;
            sat    = 1'b1;
        end else if (shifted < OUT_MIN) begin
            result = RES_MIN;
            sat    = 1'b1;
        end
    end

endmodule

// File: rtl/accumulator_requant.sv
// Saturating multiply-accumulate tail: sums a programmable number of signed
// products, requantizes the sum and offers it over a valid/ready handshake.
// Optional output ReLU: define ACCUMULATOR_REQUANT_RELU_EN (handled in requant_sat).
module accumulator_requant
    import openeye_acc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH_PROD = PROD_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH_ACC  = ACC_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH_OUT  = OUT_WIDTH_DEF,
    parameter int unsigned CNT_WIDTH       = 8,
    parameter int unsigned Q_BITWIDTH      = $clog2(DATA_WIDTH_ACC)
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic signed [DATA_WIDTH_PROD-1:0] product_i,
    input  logic                              product_valid_i,
    output logic                              product_ready_o,
    input  logic        [CNT_WIDTH-1:0]       acc_len_i,
    input  logic        [Q_BITWIDTH-1:0]      fraction_bit_i,
    input  logic                              clear_i,
    output logic signed [DATA_WIDTH_OUT-1:0]  result_o,
    output logic                              result_valid_o,
    input  logic                              result_ready_i,
    output logic                              overflow_o,
    output logic                              busy_o
);

    localparam logic signed [DATA_WIDTH_ACC:0] ACC_MAX =
        (DATA_WIDTH_ACC+1)'(sat_max(DATA_WIDTH_ACC));
    localparam logic signed [DATA_WIDTH_ACC:0] ACC_MIN =
        (DATA_WIDTH_ACC+1)'(sat_min(DATA_WIDTH_ACC));

    acc_state_t state, state_next;

    logic signed [DATA_WIDTH_ACC-1:0] acc, acc_next;
    logic signed [DATA_WIDTH_ACC:0]   sum;
    logic        [CNT_WIDTH-1:0]      cnt, cnt_next, len, len_start;
    logic        [Q_BITWIDTH-1:0]     frac, frac_sel;
    logic                             accept, start, final_acc, add_sat;
    logic signed [DATA_WIDTH_OUT-1:0] req_result;
    logic                             req_sat;

    assign product_ready_o = (state != OUTPUT) || result_ready_i;
    assign accept          = product_valid_i && product_ready_o;
    assign busy_o          = (state != IDLE);

    // Accumulator next value, count and last-product detection for this cycle.
    // A product accepted in OUTPUT implies the result handshake, so it starts
    // a new accumulation exactly like one accepted in IDLE.
    always_comb begin
        start     = accept && (state != ACCUM);
        len_start = (acc_len_i == '0) ? CNT_WIDTH'(1) : acc_len_i;
        frac_sel  = start ? fraction_bit_i : frac;
        sum       = (DATA_WIDTH_ACC+1)'(acc) + (DATA_WIDTH_ACC+1)'(product_i);
        acc_next  = acc;
        cnt_next  = cnt;
        add_sat   = 1'b0;
        final_acc = 1'b0;
        if (start) begin
            acc_next  = DATA_WIDTH_ACC'(product_i);
            cnt_next  = CNT_WIDTH'(1);
            final_acc = (len_start == CNT_WIDTH'(1));
        end else if (accept) begin
            if (sum > ACC_MAX) begin
                acc_next = ACC_MAX[DATA_WIDTH_ACC-1:0];
                add_sat  = 1'b1;
            end else if (sum < ACC_MIN) begin
                acc_next = ACC_MIN[DATA_WIDTH_ACC-1:0];
                add_sat  = 1'b1;
            end else begin
                acc_next = sum[DATA_WIDTH_ACC-1:0];
            end
            cnt_next  = cnt + 1'b1;
            final_acc = (cnt_next == len);
        end
    end

    requant_sat #(
        .DATA_WIDTH_ACC (DATA_WIDTH_ACC),
        .DATA_WIDTH_OUT (DATA_WIDTH_OUT),
        .Q_BITWIDTH     (Q_BITWIDTH)
    ) u_requant_sat (
        .acc_next (acc_next),
        .frac     (frac_sel),
        .result   (req_result),
        .sat      (req_sat)
    );

    // Next-state selection; clear overrides every transition.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) state_next = final_acc ? OUTPUT : ACCUM;
            end
            ACCUM: begin
                if (accept && final_acc) state_next = OUTPUT;
            end
            OUTPUT: begin
                if (result_ready_i) begin
                    if (accept) state_next = final_acc ? OUTPUT : ACCUM;
                    else        state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (clear_i) state_next = IDLE;
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_next;
    end

    // Accumulator, configuration latches and registered result/flags.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc            <= '0;
            cnt            <= '0;
            len            <= '0;
            frac           <= '0;
            result_o       <= '0;
            result_valid_o <= 1'b0;
            overflow_o     <= 1'b0;
        end else if (clear_i) begin
            acc            <= '0;
            cnt            <= '0;
            result_valid_o <= 1'b0;
            overflow_o     <= 1'b0;
        end else begin
            acc <= acc_next;
            cnt <= cnt_next;
            if (start) begin
                len  <= len_start;
                frac <= fraction_bit_i;
            end
            if (final_acc) begin
                result_o       <= req_result;
                result_valid_o <= 1'b1;
            end else if ((state == OUTPUT) && result_ready_i) begin
                result_valid_o <= 1'b0;
            end
            if (start) begin
                overflow_o <= final_acc && req_sat;
            end else if (accept) begin
                overflow_o <= overflow_o || add_sat || (final_acc && req_sat);
            end
        end
    end

endmodule
